// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the elastic pipeline stage chain.
package pipeline_pkg;

   localparam int DEF_DATA_SZ = 64;
   localparam int DEF_DEPTH   = 5;
   localparam int DEF_IDX_SZ  = 4;
   localparam int DEF_CNT_SZ  = 32;

   // Index of a stage within a default-sized chain (also the flush bound type).
   typedef logic [DEF_IDX_SZ-1:0] stage_idx_t;

   // Smallest index width (at least one bit) able to address n stages.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// One pipeline stage: a valid bit plus payload register.
// Flush has priority over load; the payload only changes when a valid item arrives,
// so an emptied stage keeps its last payload (harmless, since it is marked invalid).
module pipeline_stage_reg
   import pipeline_pkg::*;
#(
   parameter int DATA_SZ = DEF_DATA_SZ
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               load_en,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_SZ-1:0] in_data,
   output logic               out_valid,
   output logic [DATA_SZ-1:0] out_data
);

   logic               valid_q, valid_d;
   logic [DATA_SZ-1:0] data_q, data_d;

   // Next-state: flush clears, load takes the incoming item, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load_en) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   // Stage register with synchronous reset.
   always_ff @(posedge clk) begin
      if (srst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/pipeline_stage_chain.sv
// Elastic N-stage pipeline with per-stage stall, ranged flush, valid/ready at both
// ends and debug retire/bubble counters. Stage 0 is youngest, DEPTH-1 drives output.
module pipeline_stage_chain
   import pipeline_pkg::*;
#(
   parameter int DATA_SZ = DEF_DATA_SZ,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int IDX_SZ  = DEF_IDX_SZ,
   parameter int CNT_SZ  = DEF_CNT_SZ
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [DATA_SZ-1:0] i_data,
   output logic               o_ready,
   input  logic [DEPTH-1:0]   i_stall,
   input  logic               i_flush,
   input  logic [IDX_SZ-1:0]  i_flush_stage,
   output logic               o_valid,
   output logic [DATA_SZ-1:0] o_data,
   input  logic               i_ready,
   output logic [DEPTH-1:0]   o_stage_valid,
   input  logic               i_cnt_clr,
   output logic [CNT_SZ-1:0]  o_retired_cnt,
   output logic [CNT_SZ-1:0]  o_bubble_cnt
);

   logic [DEPTH:0]     acc;         // stage k can take a new item this cycle
   logic [DEPTH-1:0]   mv;          // stage k hands its item onward this cycle
   logic [DEPTH-1:0]   stage_v;
   logic [DEPTH-1:0]   flush_clr;   // stage k is squashed this cycle
   int                 flush_bound;
   logic [DATA_SZ-1:0] stage_d    [DEPTH];
   logic               stage_in_v [DEPTH];
   logic [DATA_SZ-1:0] stage_in_d [DEPTH];

   logic              retire_inc, bubble_inc;
   logic [CNT_SZ-1:0] retired_q, retired_d;
   logic [CNT_SZ-1:0] bubble_q, bubble_d;

   // Advance network, oldest to youngest: a stage accepts when unstalled and either
   // empty or its own item is leaving, so a full chain moves in lockstep.
   always_comb begin
      acc        = '0;
      mv         = '0;
      acc[DEPTH] = i_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         mv[k]  = stage_v[k] & ~i_stall[k] & acc[k+1];
         acc[k] = ~i_stall[k] & (~stage_v[k] | mv[k]);
      end
   end

   // Flush range: stages 0..F are squashed, F clamped to the oldest stage.
   always_comb begin
      flush_bound = int'(i_flush_stage);
      if (flush_bound > DEPTH - 1) begin
         flush_bound = DEPTH - 1;
      end
      flush_clr = '0;
      for (int k = 0; k < DEPTH; k++) begin
         flush_clr[k] = i_flush & (k <= flush_bound);
      end
   end

   assign o_ready = acc[0] & ~i_flush;

   // Stage instances; each stage's input is the item leaving its younger neighbour,
   // masked when that neighbour is being squashed.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_in_v[gi] = i_valid & o_ready;
            assign stage_in_d[gi] = i_data;
         end else begin : g_body
            assign stage_in_v[gi] = mv[gi-1] & ~flush_clr[gi-1];
            assign stage_in_d[gi] = stage_d[gi-1];
         end

         pipeline_stage_reg #(
            .DATA_SZ (DATA_SZ)
         ) u_stage (
            .clk       (i_clk),
            .srst      (i_reset),
            .load_en   (acc[gi]),
            .flush     (flush_clr[gi]),
            .in_valid  (stage_in_v[gi]),
            .in_data   (stage_in_d[gi]),
            .out_valid (stage_v[gi]),
            .out_data  (stage_d[gi])
         );
      end
   endgenerate

   assign o_valid       = stage_v[DEPTH-1] & ~i_stall[DEPTH-1];
   assign o_data        = stage_d[DEPTH-1];
   assign o_stage_valid = stage_v;

   // A squash of the oldest stage cancels a same-cycle output transfer.
   assign retire_inc = o_valid & i_ready & ~flush_clr[DEPTH-1];
   assign bubble_inc = i_ready & ~o_valid;

   // Counter next-state: wrap naturally, clear beats increment.
   always_comb begin
      retired_d = retired_q + CNT_SZ'(retire_inc);
      bubble_d  = bubble_q + CNT_SZ'(bubble_inc);
      if (i_cnt_clr) begin
         retired_d = '0;
         bubble_d  = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         retired_q <= '0;
         bubble_q  <= '0;
      end else begin
         retired_q <= retired_d;
         bubble_q  <= bubble_d;
      end
   end

   assign o_retired_cnt = retired_q;
   assign o_bubble_cnt  = bubble_q;

endmodule
